// File: rtl/lockpick_pkg.sv
// Shared types, state encodings, result codes and message words for the lockpick host.
package lockpick_pkg;

  localparam int unsigned KEY_BYTES_DEFAULT = 32;

  typedef logic [2:0] host_state_t;
  localparam host_state_t ST_IDLE      = 3'd0;
  localparam host_state_t ST_START     = 3'd1;
  localparam host_state_t ST_SEND_A    = 3'd2;
  localparam host_state_t ST_SEND_B    = 3'd3;
  localparam host_state_t ST_WAIT_RESP = 3'd4;
  localparam host_state_t ST_RECV      = 3'd5;
  localparam host_state_t ST_DONE      = 3'd6;

  typedef logic [1:0] result_t;
  localparam result_t RES_FAULT  = 2'b00;
  localparam result_t RES_ERROR  = 2'b01;
  localparam result_t RES_WIN    = 2'b10;
  localparam result_t RES_LOCKED = 2'b11;

  localparam logic [31:0] MSG_WIN    = 32'hFACEFACE;
  localparam logic [31:0] MSG_LOCKED = 32'hDEADDEAD;
  localparam logic [31:0] MSG_ERROR  = 32'hBAD0BAD0;

endpackage

// File: rtl/lockpick_byte_tx.sv
// Paced byte serializer: loads a word, emits it LSB-first, one byte then GAP_CYC idle cycles.
module lockpick_byte_tx #(
  parameter int unsigned KEY_BYTES = 32,
  parameter int unsigned GAP_CYC   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [8*KEY_BYTES-1:0] load_word,
  output logic                   byte_en,
  output logic [7:0]             byte_data,
  output logic                   last_byte_c,
  output logic                   free_c
);

  localparam int unsigned IDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int unsigned GAP_W = (GAP_CYC < 1) ? 1 : $clog2(GAP_CYC + 1);

  logic [8*KEY_BYTES-1:0] word_q, word_d;
  logic [IDX_W-1:0]       idx_q, idx_d, nxt_idx;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   en_q, en_d;
  logic [7:0]             data_q, data_d;
  logic                   active_q, active_d;
  logic                   is_last_c, slot_end_c;

  assign nxt_idx     = idx_q + IDX_W'(1);
  assign is_last_c   = (idx_q == IDX_W'(KEY_BYTES - 1));
  assign slot_end_c  = en_q ? (GAP_CYC == 0) : (gap_q == GAP_W'(GAP_CYC));
  assign last_byte_c = en_q && is_last_c;
  assign free_c      = active_q && is_last_c && slot_end_c;
  assign byte_en     = en_q;
  assign byte_data   = data_q;

  // Next byte slot: emit, count gap, or go idle after the last slot.
  always_comb begin
    word_d   = word_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    en_d     = 1'b0;
    data_d   = 8'h00;
    active_d = active_q;
    if (load) begin
      word_d   = load_word;
      idx_d    = '0;
      gap_d    = '0;
      en_d     = 1'b1;
      data_d   = load_word[7:0];
      active_d = 1'b1;
    end else if (active_q) begin
      if (slot_end_c) begin
        if (is_last_c) begin
          active_d = 1'b0;
          idx_d    = '0;
        end else begin
          idx_d  = nxt_idx;
          gap_d  = '0;
          en_d   = 1'b1;
          data_d = word_q[8*nxt_idx +: 8];
        end
      end else if (en_q) begin
        gap_d = GAP_W'(1);
      end else if (gap_q != GAP_W'(GAP_CYC)) begin
        gap_d = gap_q + GAP_W'(1);
      end
    end
  end

  // Serializer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= '0;
      idx_q    <= '0;
      gap_q    <= '0;
      en_q     <= 1'b0;
      data_q   <= 8'h00;
      active_q <= 1'b0;
    end else begin
      word_q   <= word_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      en_q     <= en_d;
      data_q   <= data_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/lockpick_host.sv
// Host driver for the lockpick game: sends two keys, captures and decodes the result message.
module lockpick_host
  import lockpick_pkg::*;
#(
  parameter int unsigned KEY_BYTES   = KEY_BYTES_DEFAULT,
  parameter int unsigned GAP_CYC     = 0,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   go,
  input  logic [8*KEY_BYTES-1:0] key_a,
  input  logic [8*KEY_BYTES-1:0] key_b,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             result,
  output logic [1:0]             resp_status,
  output logic                   start,
  output logic                   input_enable,
  output logic [7:0]             input_data,
  input  logic                   output_valid,
  input  logic [7:0]             output_data,
  input  logic [1:0]             status
);

  localparam int unsigned IDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  host_state_t            state_q, state_d;
  logic [8*KEY_BYTES-1:0] key_a_q, key_a_d, key_b_q, key_b_d;
  logic [8*KEY_BYTES-1:0] resp_q, resp_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d, done_q, done_d, start_q, start_d;
  result_t                result_q, result_d;
  logic [1:0]             resp_status_q, resp_status_d;
  logic                   tx_load_c, tx_last_c, tx_free_c;
  logic [8*KEY_BYTES-1:0] tx_word_c;

  // True when every message byte repeats the 4-byte word, LSB-first.
  function automatic logic msg_is(input logic [8*KEY_BYTES-1:0] msg, input logic [31:0] w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < int'(KEY_BYTES); i++)
      if (msg[8*i +: 8] != w[8*(i%4) +: 8]) ok = 1'b0;
    return ok;
  endfunction

  function automatic result_t decode_msg(input logic [8*KEY_BYTES-1:0] msg);
    if (msg_is(msg, MSG_WIN))         return RES_WIN;
    else if (msg_is(msg, MSG_LOCKED)) return RES_LOCKED;
    else if (msg_is(msg, MSG_ERROR))  return RES_ERROR;
    else                              return RES_FAULT;
  endfunction

  lockpick_byte_tx #(.KEY_BYTES(KEY_BYTES), .GAP_CYC(GAP_CYC)) u_tx (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (tx_load_c),
    .load_word   (tx_word_c),
    .byte_en     (input_enable),
    .byte_data   (input_data),
    .last_byte_c (tx_last_c),
    .free_c      (tx_free_c)
  );

  // Attempt sequencing, response capture and decode.
  always_comb begin
    state_d       = state_q;
    key_a_d       = key_a_q;
    key_b_d       = key_b_q;
    resp_d        = resp_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    start_d       = 1'b0;
    result_d      = result_q;
    resp_status_d = resp_status_q;
    tx_load_c     = 1'b0;
    tx_word_c     = key_a_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          key_a_d = key_a;
          key_b_d = key_b;
          busy_d  = 1'b1;
          start_d = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx_load_c = 1'b1;
        state_d   = ST_SEND_A;
      end
      ST_SEND_A: begin
        if (tx_free_c) begin
          tx_load_c = 1'b1;
          tx_word_c = key_b_q;
          state_d   = ST_SEND_B;
        end
      end
      ST_SEND_B: begin
        if (tx_last_c) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        if (output_valid) begin
          resp_d[7:0] = output_data;
          idx_d       = IDX_W'(1);
          state_d     = ST_RECV;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          result_d = RES_FAULT;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RECV: begin
        if (output_valid) begin
          resp_d[8*idx_q +: 8] = output_data;
          idx_d                = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(KEY_BYTES - 1)) begin
            resp_status_d = status;
            result_d      = decode_msg(resp_d);
            done_d        = 1'b1;
            idx_d         = '0;
            state_d       = ST_DONE;
          end
        end else begin
          result_d = RES_FAULT;
          done_d   = 1'b1;
          idx_d    = '0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Host state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      key_a_q       <= '0;
      key_b_q       <= '0;
      resp_q        <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      start_q       <= 1'b0;
      result_q      <= RES_FAULT;
      resp_status_q <= 2'b00;
    end else begin
      state_q       <= state_d;
      key_a_q       <= key_a_d;
      key_b_q       <= key_b_d;
      resp_q        <= resp_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      start_q       <= start_d;
      result_q      <= result_d;
      resp_status_q <= resp_status_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign resp_status = resp_status_q;
  assign start       = start_q;

endmodule

// File: tb/tb_lockpick_host.sv
// Scoreboard bench for lockpick_host: game responder model, byte and result queues.
module tb_lockpick_host;
  import lockpick_pkg::*;

  localparam int unsigned KB  = 32;
  localparam int unsigned TMO = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT (back-to-back bytes)
  logic           go, busy, done, start, input_enable, output_valid;
  logic [255:0]   key_a, key_b;
  logic [1:0]     result, resp_status, status;
  logic [7:0]     input_data, output_data;

  // second DUT with two idle cycles per byte, no responder
  logic           g_go, g_busy, g_done, g_start, g_input_enable, g_output_valid;
  logic [255:0]   g_key_a, g_key_b;
  logic [1:0]     g_result, g_resp_status, g_status;
  logic [7:0]     g_input_data, g_output_data;

  lockpick_host dut (
    .clk(clk), .rst_n(rst_n), .go(go), .key_a(key_a), .key_b(key_b),
    .busy(busy), .done(done), .result(result), .resp_status(resp_status),
    .start(start), .input_enable(input_enable), .input_data(input_data),
    .output_valid(output_valid), .output_data(output_data), .status(status)
  );

  lockpick_host #(.GAP_CYC(2)) dut_g (
    .clk(clk), .rst_n(rst_n), .go(g_go), .key_a(g_key_a), .key_b(g_key_b),
    .busy(g_busy), .done(g_done), .result(g_result), .resp_status(g_resp_status),
    .start(g_start), .input_enable(g_input_enable), .input_data(g_input_data),
    .output_valid(g_output_valid), .output_data(g_output_data), .status(g_status)
  );

  typedef struct packed {logic [1:0] res; logic [1:0] st; logic chk_st;} exp_t;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] byte_q[$];
  exp_t       res_q[$];

  int          rsp_mode;     // 0 full message, 1 silent, 2 stop after 10 bytes
  logic [31:0] rsp_word;
  int          rsp_corrupt;
  logic [1:0]  rsp_status;
  int unsigned last_rsp_cyc, last_en_cyc, first_en_cyc, done_cyc;
  int          done_cnt = 0;
  int          start_cnt = 0;

  // Game responder: after 64 key bytes, answer 3 cycles later.
  initial begin : responder
    int en_cnt;
    int nbytes;
    en_cnt = 0;
    output_valid = 1'b0; output_data = 8'h00; status = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n || start) en_cnt = 0;
      else if (input_enable) begin
        en_cnt++;
        if (en_cnt == 2*KB && rsp_mode != 1) begin
          nbytes = (rsp_mode == 2) ? 10 : KB;
          repeat (2) @(negedge clk);
          for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            output_valid = 1'b1;
            output_data  = rsp_word[8*(i%4) +: 8] ^ ((i == rsp_corrupt) ? 8'h01 : 8'h00);
            status       = (i == KB-1) ? rsp_status : 2'b10;
            last_rsp_cyc = cyc;
          end
          @(negedge clk);
          output_valid = 1'b0; output_data = 8'h00; status = 2'b00;
          en_cnt = 0;
        end
      end
    end
  end

  // Output monitor: pops expected key bytes and results.
  initial begin : monitor
    logic [7:0] eb;
    exp_t       er;
    bit         need_first;
    need_first = 1'b0;
    forever begin
      @(negedge clk);
      if (start) begin start_cnt++; need_first = 1'b1; end
      if (input_enable) begin
        last_en_cyc = cyc;
        if (need_first) begin first_en_cyc = cyc; need_first = 1'b0; end
        vectors++;
        if (byte_q.size() == 0) begin
          miscompares++;
          $display("FAIL key_byte: unexpected byte %02h, none required", input_data);
        end else begin
          eb = byte_q.pop_front();
          if (input_data !== eb) begin
            miscompares++;
            $display("FAIL key_byte: got %02h required %02h", input_data, eb);
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        vectors++;
        if (res_q.size() == 0) begin
          miscompares++;
          $display("FAIL done_pulse: unexpected done, result %0b", result);
        end else begin
          er = res_q.pop_front();
          if (result !== er.res) begin
            miscompares++;
            $display("FAIL result: got %02b required %02b", result, er.res);
          end
          if (er.chk_st) begin
            vectors++;
            if (resp_status !== er.st) begin
              miscompares++;
              $display("FAIL resp_status: got %02b required %02b", resp_status, er.st);
            end
          end
        end
      end
    end
  end

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic run_attempt(input logic [255:0] ka, input logic [255:0] kb, input int mode,
                             input logic [31:0] w, input int corrupt, input logic [1:0] st,
                             input logic [1:0] exp_res, input bit chk_st, input bit extra_go);
    int sc0, dc0;
    bit got;
    rsp_mode = mode; rsp_word = w; rsp_corrupt = corrupt; rsp_status = st;
    for (int i = 0; i < int'(KB); i++) byte_q.push_back(ka[8*i +: 8]);
    for (int i = 0; i < int'(KB); i++) byte_q.push_back(kb[8*i +: 8]);
    res_q.push_back('{res: exp_res, st: st, chk_st: chk_st});
    sc0 = start_cnt; dc0 = done_cnt;
    key_a = ka; key_b = kb; go = 1'b1;
    @(negedge clk);
    go = 1'b0; key_a = ~ka; key_b = ~kb;
    vectors++;
    if ({start, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL start_pulse: start,busy got %02b required 11", {start, busy});
    end
    @(negedge clk);
    vectors++;
    if ({start, input_enable, input_data} !== {1'b0, 1'b1, ka[7:0]}) begin
      miscompares++;
      $display("FAIL first_byte: start,en,data got %0b,%0b,%02h required 0,1,%02h",
               start, input_enable, input_data, ka[7:0]);
    end
    if (extra_go) begin
      repeat (20) @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
    end
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (done_cnt != dc0) got = 1'b1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL done_timeout: no done within 400 cycles, required one");
    end
    repeat (6) @(negedge clk);
    vectors++;
    if ({done_cnt - dc0, start_cnt - sc0, 31'(byte_q.size()), busy} !== {32'd1, 32'd1, 31'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL attempt_end: dones %0d starts %0d bytes_left %0d busy %0b required 1 1 0 0",
               done_cnt - dc0, start_cnt - sc0, byte_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, result, resp_status, start, input_enable, input_data} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %04h required 0000",
               {busy, done, result, resp_status, start, input_enable, input_data});
    end
    vectors++;
    if ({g_busy, g_done, g_result, g_resp_status, g_start, g_input_enable, g_input_data} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_outputs_gap: got %04h required 0000",
               {g_busy, g_done, g_result, g_resp_status, g_start, g_input_enable, g_input_data});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_error_resp();
    run_attempt('0, '0, 0, MSG_ERROR, -1, 2'b01, RES_ERROR, 1'b1, 1'b0);
    vectors++;
    if (last_en_cyc - first_en_cyc !== 63) begin
      miscompares++;
      $display("FAIL enable_span: got %0d cycles required 63", last_en_cyc - first_en_cyc);
    end
    vectors++;
    if (done_cyc - last_rsp_cyc !== 1) begin
      miscompares++;
      $display("FAIL done_latency: got %0d required 1", done_cyc - last_rsp_cyc);
    end
  endtask

  task automatic test_win_locked();
    run_attempt(rnd256(), rnd256(), 0, MSG_WIN, -1, 2'b11, RES_WIN, 1'b1, 1'b0);
    run_attempt(rnd256(), rnd256(), 0, MSG_LOCKED, -1, 2'b00, RES_LOCKED, 1'b1, 1'b0);
  endtask

  task automatic test_gap();
    logic [255:0] kb;
    logic         exp_en;
    logic [7:0]   exp_d;
    int           k, pos;
    kb = rnd256();
    for (int i = 0; i < int'(KB); i++) g_key_a[8*i +: 8] = 8'(i);
    g_key_b = kb; g_go = 1'b1;
    @(negedge clk);
    g_go = 1'b0;
    vectors++;
    if (g_start !== 1'b1) begin
      miscompares++;
      $display("FAIL gap_start: got %0b required 1", g_start);
    end
    for (int c = 0; c < 6*int'(KB); c++) begin
      @(negedge clk);
      exp_en = (c % 3 == 0);
      k = c / 3;
      exp_d = !exp_en ? 8'h00 : (k < int'(KB)) ? 8'(k) : kb[8*(k-int'(KB)) +: 8];
      vectors++;
      if ({g_input_enable, g_input_data} !== {exp_en, exp_d}) begin
        miscompares++;
        $display("FAIL gap_byte[%0d]: en,data got %0b,%02h required %0b,%02h",
                 c, g_input_enable, g_input_data, exp_en, exp_d);
      end
    end
    pos = 6*int'(KB) - 1;
    while (!g_done && pos < 400) begin
      @(negedge clk);
      pos++;
    end
    vectors++;
    if ({g_done, g_result} !== {1'b1, RES_FAULT} || pos != 189 + int'(TMO) + 1) begin
      miscompares++;
      $display("FAIL gap_timeout: done %0b result %02b at %0d, required 1 00 at %0d",
               g_done, g_result, pos, 189 + TMO + 1);
    end
  endtask

  task automatic test_timeout();
    run_attempt(rnd256(), rnd256(), 1, MSG_WIN, -1, 2'b00, RES_FAULT, 1'b0, 1'b0);
    vectors++;
    if (done_cyc - last_en_cyc !== TMO + 1) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d required %0d", done_cyc - last_en_cyc, TMO + 1);
    end
  endtask

  task automatic test_drop_corrupt();
    run_attempt(rnd256(), rnd256(), 2, MSG_WIN, -1, 2'b00, RES_FAULT, 1'b0, 1'b0);
    vectors++;
    if (done_cyc - last_rsp_cyc !== 2) begin
      miscompares++;
      $display("FAIL drop_latency: got %0d required 2", done_cyc - last_rsp_cyc);
    end
    run_attempt(rnd256(), rnd256(), 0, MSG_WIN, 17, 2'b01, RES_FAULT, 1'b1, 1'b0);
  endtask

  task automatic test_busy_go();
    run_attempt(rnd256(), rnd256(), 0, MSG_WIN, -1, 2'b10, RES_WIN, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [255:0] ka, kb;
    int dc0;
    ka = rnd256(); kb = rnd256();
    for (int i = 0; i < int'(KB); i++) byte_q.push_back(ka[8*i +: 8]);
    for (int i = 0; i < int'(KB); i++) byte_q.push_back(kb[8*i +: 8]);
    key_a = ka; key_b = kb; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int k = 0; k < 200 && byte_q.size() > 24; k++) @(negedge clk);
    vectors++;
    if (byte_q.size() > 24) begin
      miscompares++;
      $display("FAIL reset_mid_progress: %0d bytes left, required <= 24", byte_q.size());
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, result, resp_status, start, input_enable, input_data} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got %04h required 0000",
               {busy, done, result, resp_status, start, input_enable, input_data});
    end
    byte_q.delete();
    dc0 = done_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    vectors++;
    if (done_cnt != dc0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_nodone: dones %0d busy %0b required 0 0", done_cnt - dc0, busy);
    end
    run_attempt(rnd256(), rnd256(), 0, MSG_ERROR, -1, 2'b01, RES_ERROR, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; key_a = '0; key_b = '0;
    g_go = 1'b0; g_key_a = '0; g_key_b = '0;
    g_output_valid = 1'b0; g_output_data = 8'h00; g_status = 2'b00;
    rsp_mode = 0; rsp_word = '0; rsp_corrupt = -1; rsp_status = 2'b00;
    test_reset();
    test_error_resp();
    test_win_locked();
    test_gap();
    test_timeout();
    test_drop_corrupt();
    test_busy_go();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
